// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: the immsrc values used by the extend unit and the
// immediate encoder, plus the sign-range helper both rely on.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam int unsigned XLEN = 32;

    // True when bits [31:msb] are all copies of the sign bit, i.e. the value
    // survives truncation to a (msb+1)-bit signed field.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned msb);
        logic [31:0] shifted_v;
        shifted_v = $signed(value) >>> msb;
        return (shifted_v == 32'h0000_0000) || (shifted_v == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Scatters a signed immediate into the I/S/B/J bit positions of a base
// instruction and flags values the chosen format cannot represent.
module imm_pack
    import riscv_pkg::*;
(
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        err
);

    // Field packing and legality; the truncated word is emitted even when illegal
    always_comb begin
        instr = base;
        err   = 1'b0;
        case (imm_src_e'(immsrc))
            IMM_I: begin
                instr[31:20] = imm[11:0];
                err          = ~fits_signed(imm, 32'd11);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                err          = ~fits_signed(imm, 32'd11);
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                err          = imm[0] | ~fits_signed(imm, 32'd12);
            end
            IMM_J: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
                err          = imm[0] | ~fits_signed(imm, 32'd20);
            end
            default: begin
                instr = base;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs requests through imm_pack into an in-order output
// FIFO with registered handshakes and accept/illegal counters.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_immsrc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1'b1);

    logic [31:0]      pack_instr_s;
    logic             pack_err_s;
    logic [32:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [32:0]      head_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [31:0]      out_instr_r;
    logic             out_err_r;
    logic [15:0]      enc_count_r;
    logic [15:0]      err_count_r;

    imm_pack u_pack (
        .immsrc (in_immsrc),
        .imm    (in_imm),
        .base   (in_base),
        .instr  (pack_instr_s),
        .err    (pack_err_s)
    );

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_ready & out_valid_r;

    // Next pointers/occupancy and the word that will be at the head after this edge
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = 33'd0;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
        // A word pushed into the slot that becomes the head bypasses storage
        if (count_nxt_s == '0) begin
            head_nxt_s = 33'd0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = {pack_err_s, pack_instr_s};
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, written on every accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= 33'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {pack_err_s, pack_instr_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and the registered handshake/output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_err_r   <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s < DEPTH_C);
            out_valid_r <= (count_nxt_s != '0);
            out_instr_r <= head_nxt_s[31:0];
            out_err_r   <= head_nxt_s[32];
        end
    end

    // Accept counter wraps; illegal counter saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_r <= 16'd0;
            err_count_r <= 16'd0;
        end else if (push_s) begin
            enc_count_r <= enc_count_r + 16'd1;
            if (pack_err_s && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end else begin
            enc_count_r <= enc_count_r;
            err_count_r <= err_count_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_err   = out_err_r;
    assign enc_count = enc_count_r;
    assign err_count = err_count_r;

endmodule
